// File: rtl/ts_energy_dispersal.sv
// ts_energy_dispersal
//   Byte-wise DVB energy-dispersal scrambler. The PRBS generator is
//   1 + X^14 + X^15 and runs over groups of GROUP_PKTS transport-stream
//   packets of PKT_LEN bytes each. The sync byte of packet 1 of each group
//   is inverted and reloads the PRBS. The sync bytes of packets 2..8 pass
//   through unchanged, but the PRBS keeps stepping through them.
//   The block has one cycle of latency, and every output is registered.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   din        input TS byte (MSB first in time)
//   din_valid  din qualifier; gaps allowed, no backpressure
//   din_sop    din is a sync byte (packet byte 0), sampled with din_valid
//   dout       scrambled byte
//   dout_valid dout qualifier
//   dout_sop   dout sits in a sync-byte position
//   group_sop  dout is the inverted sync byte of packet 1 of a group
//   sync_err   one-cycle framing-error pulse, aligned with the offending byte
module ts_energy_dispersal #(
  parameter int          PKT_LEN    = 188,
  parameter int          GROUP_PKTS = 8,
  parameter logic [7:0]  SYNC_BYTE  = 8'h47,
  parameter logic [14:0] PRBS_INIT  = 15'b100101010000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       din_valid,
  input  logic       din_sop,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       dout_sop,
  output logic       group_sop,
  output logic       sync_err
);

  localparam int BCW = $clog2(PKT_LEN);
  localparam int PCW = (GROUP_PKTS > 1) ? $clog2(GROUP_PKTS) : 1;
  localparam logic [BCW-1:0] BYTE_LAST = BCW'(PKT_LEN - 1);
  localparam logic [PCW-1:0] PKT_LAST  = PCW'(GROUP_PKTS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]     state;
  logic [BCW-1:0] byte_cnt;
  logic [PCW-1:0] pkt_cnt;

  // prbs[14] holds reg1 and prbs[0] holds reg15.
  // With this layout, the PRBS_INIT literal reads left to right as reg1..reg15.
  logic [14:0] prbs;
  logic [14:0] prbs_adv;
  logic [7:0]  prbs_byte;
  logic        fb;

  // Eight generator steps per byte. The first step lands in prbs_byte[7].
  always_comb begin
    prbs_adv  = prbs;
    prbs_byte = '0;
    fb        = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fb        = prbs_adv[1] ^ prbs_adv[0];
      prbs_byte = {prbs_byte[6:0], fb};
      prbs_adv  = {fb, prbs_adv[14:1]};
    end
  end

  // Byte classification.
  // start_grp covers both the first sop seen in IDLE and a mid-packet sop.
  // A mid-packet sop restarts the group and takes priority over everything else.
  logic start_grp, restart, lost, sync_hit, data_byte, bad_sync;

  always_comb begin
    restart   = (state == RUN) && din_valid && din_sop && (byte_cnt != '0);
    start_grp = ((state == IDLE) && din_valid && din_sop) || restart;
    lost      = (state == RUN) && din_valid && !din_sop && (byte_cnt == '0);
    sync_hit  = (state == RUN) && din_valid && din_sop && (byte_cnt == '0);
    data_byte = (state == RUN) && din_valid && !din_sop && (byte_cnt != '0);
    bad_sync  = din_valid && din_sop && (din != SYNC_BYTE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      pkt_cnt    <= '0;
      prbs       <= PRBS_INIT;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_sop   <= 1'b0;
      group_sop  <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      dout_sop   <= 1'b0;
      group_sop  <= 1'b0;
      sync_err   <= 1'b0;
      if (start_grp) begin
        dout       <= ~din;
        dout_valid <= 1'b1;
        dout_sop   <= 1'b1;
        group_sop  <= 1'b1;
        sync_err   <= restart | bad_sync;
        prbs       <= PRBS_INIT;
        byte_cnt   <= BCW'(1);
        pkt_cnt    <= '0;
        state      <= RUN;
      end else if (lost) begin
        // The sync byte is missing, so drop the byte and hunt for the next sop.
        sync_err <= 1'b1;
        byte_cnt <= '0;
        pkt_cnt  <= '0;
        state    <= IDLE;
      end else if (sync_hit) begin
        dout_valid <= 1'b1;
        dout_sop   <= 1'b1;
        sync_err   <= bad_sync;
        byte_cnt   <= BCW'(1);
        if (pkt_cnt == '0) begin
          dout      <= ~din;
          group_sop <= 1'b1;
          prbs      <= PRBS_INIT;
        end else begin
          // The sync byte passes through, but the PRBS keeps stepping behind it.
          dout <= din;
          prbs <= prbs_adv;
        end
      end else if (data_byte) begin
        dout       <= din ^ prbs_byte;
        dout_valid <= 1'b1;
        prbs       <= prbs_adv;
        if (byte_cnt == BYTE_LAST) begin
          byte_cnt <= '0;
          pkt_cnt  <= (pkt_cnt == PKT_LAST) ? '0 : pkt_cnt + 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ts_energy_dispersal.sv
// tb_ts_energy_dispersal
//   Testbench for ts_energy_dispersal. A reference model of the scrambler
//   pushes the expected output for every driven cycle into a queue. That
//   entry is popped and compared after the clock edge that produces it.
//   Known fixed byte values (0xB8, 0x03, 0xF6, 0x47) are also checked directly.
module tb_ts_energy_dispersal;

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       din_valid;
  logic       din_sop;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_sop;
  logic       group_sop;
  logic       sync_err;

  ts_energy_dispersal dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_sop    (din_sop),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_sop   (dout_sop),
    .group_sop  (group_sop),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
    logic       sop;
    logic       gsop;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   gap_en = 0;

  logic [7:0] last_dout;
  logic       last_valid, last_gsop, last_err;

  // Reference model. r[1..15] holds the PRBS shift register, and a packet counter tracks group position.
  bit       m_run;
  int       m_bc, m_pc;
  bit [1:15] r;

  task automatic model_reset();
    m_run = 0; m_bc = 0; m_pc = 0;
    r = 15'b100101010000000;
  endtask

  task automatic next_prbs(output logic [7:0] b);
    bit o;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      o = r[14] ^ r[15];
      b = {b[6:0], o};
      r = {o, r[1:14]};
    end
  endtask

  task automatic model(input logic [7:0] d, input logic v, input logic s, output exp_t e);
    logic [7:0] pb;
    e = '0;
    if (v) begin
      if (s && (!m_run || m_bc != 0)) begin
        e.valid = 1; e.sop = 1; e.gsop = 1; e.data = ~d;
        e.err = (m_run && m_bc != 0) || (d != 8'h47);
        r = 15'b100101010000000;
        m_run = 1; m_bc = 1; m_pc = 0;
      end else if (m_run && m_bc == 0 && !s) begin
        e.err = 1; m_run = 0;
      end else if (m_run && m_bc == 0) begin
        e.valid = 1; e.sop = 1; e.err = (d != 8'h47);
        if (m_pc == 0) begin
          e.gsop = 1; e.data = ~d; r = 15'b100101010000000;
        end else begin
          e.data = d; next_prbs(pb);
        end
        m_bc = 1;
      end else if (m_run) begin
        next_prbs(pb);
        e.valid = 1; e.data = d ^ pb;
        m_bc++;
        if (m_bc == 188) begin
          m_bc = 0; m_pc = (m_pc + 1) % 8;
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input logic v, input logic s);
    exp_t e;
    @(negedge clk);
    din = d; din_valid = v; din_sop = s;
    model(d, v, s, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    total++;
    if (dout_valid !== e.valid || dout_sop !== e.sop || group_sop !== e.gsop ||
        sync_err !== e.err || (e.valid && dout !== e.data)) begin
      bad++;
      $display("[TB] FAIL scoreboard t=%0t: got v=%b d=%h sop=%b gsop=%b err=%b want v=%b d=%h sop=%b gsop=%b err=%b",
               $time, dout_valid, dout, dout_sop, group_sop, sync_err,
               e.valid, e.data, e.sop, e.gsop, e.err);
    end
    last_dout = dout; last_valid = dout_valid; last_gsop = group_sop; last_err = sync_err;
  endtask

  // Optionally inserts an idle cycle, with random din/sop, ahead of each real byte.
  task automatic put(input logic [7:0] d, input logic s);
    if (gap_en && $urandom_range(0, 2) == 0)
      send(8'($urandom_range(0, 255)), 1'b0, 1'($urandom_range(0, 1)));
    send(d, 1'b1, s);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) put(8'h00, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 0; din = 0; din_valid = 0; din_sop = 0;
    model_reset();
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset();
    reset = 1; din = 0; din_valid = 0; din_sop = 0;
    model_reset();
    #7 reset = 0;
    #1;
    total++;
    if ({dout, dout_valid, dout_sop, group_sop, sync_err} !== 12'h000) begin
      bad++;
      $display("[TB] FAIL reset_state: got d=%h v=%b sop=%b gsop=%b err=%b want all 0",
               dout, dout_valid, dout_sop, group_sop, sync_err);
    end
    repeat (2) @(negedge clk);
    reset = 1;
    // Bytes without sop are dropped while the block hunts for sync.
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b0);
  endtask

  task automatic test_sync_start();
    put(8'h47, 1'b1);
    total++;
    if (last_dout !== 8'hB8 || last_gsop !== 1'b1) begin
      bad++; $display("[TB] FAIL first_sync: got %h/%b want b8/1", last_dout, last_gsop);
    end
    put(8'h00, 1'b0);
    total++;
    if (last_dout !== 8'h03) begin
      bad++; $display("[TB] FAIL prbs_byte0: got %h want 03", last_dout);
    end
    put(8'h00, 1'b0);
    total++;
    if (last_dout !== 8'hF6) begin
      bad++; $display("[TB] FAIL prbs_byte1: got %h want f6", last_dout);
    end
    send_zeros(185);
  endtask

  task automatic test_group_wrap();
    for (int p = 2; p <= 8; p++) begin
      put(8'h47, 1'b1);
      total++;
      if (last_dout !== 8'h47 || last_gsop !== 1'b0) begin
        bad++; $display("[TB] FAIL plain_sync pkt%0d: got %h/%b want 47/0", p, last_dout, last_gsop);
      end
      send_zeros(187);
    end
    put(8'h47, 1'b1);
    total++;
    if (last_dout !== 8'hB8 || last_gsop !== 1'b1) begin
      bad++; $display("[TB] FAIL pkt9_sync: got %h/%b want b8/1", last_dout, last_gsop);
    end
    put(8'h00, 1'b0);
    total++;
    if (last_dout !== 8'h03) begin
      bad++; $display("[TB] FAIL pkt9_byte1: got %h want 03", last_dout);
    end
    send_zeros(186);
  endtask

  task automatic test_gaps();
    apply_reset();
    gap_en = 1;
    test_sync_start();
    test_group_wrap();
    gap_en = 0;
  endtask

  task automatic test_mid_sop();
    apply_reset();
    for (int p = 0; p < 2; p++) begin
      put(8'h47, 1'b1);
      send_zeros(187);
    end
    put(8'h47, 1'b1);
    send_zeros(49);
    put(8'h47, 1'b1);
    total++;
    if (last_err !== 1'b1 || last_dout !== 8'hB8) begin
      bad++; $display("[TB] FAIL mid_sop: got err=%b d=%h want 1/b8", last_err, last_dout);
    end
    put(8'h00, 1'b0);
    total++;
    if (last_dout !== 8'h03 || last_err !== 1'b0) begin
      bad++; $display("[TB] FAIL mid_sop_next: got %h/%b want 03/0", last_dout, last_err);
    end
    send_zeros(186);
    put(8'h47, 1'b1);
    send_zeros(187);
  endtask

  task automatic test_missing_sop();
    put(8'h00, 1'b0);
    total++;
    if (last_err !== 1'b1 || last_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL missing_sop: got err=%b v=%b want 1/0", last_err, last_valid);
    end
    send_zeros(3);
    put(8'h47, 1'b1);
    total++;
    if (last_dout !== 8'hB8 || last_gsop !== 1'b1) begin
      bad++; $display("[TB] FAIL resync: got %h/%b want b8/1", last_dout, last_gsop);
    end
    put(8'h00, 1'b0);
    total++;
    if (last_dout !== 8'h03) begin
      bad++; $display("[TB] FAIL resync_byte1: got %h want 03", last_dout);
    end
    send_zeros(186);
  endtask

  task automatic test_bad_sync();
    put(8'h12, 1'b1);
    total++;
    if (last_err !== 1'b1 || last_dout !== 8'h12 || last_valid !== 1'b1) begin
      bad++; $display("[TB] FAIL bad_sync: got err=%b d=%h v=%b want 1/12/1", last_err, last_dout, last_valid);
    end
    send_zeros(187);
  endtask

  task automatic test_reset_mid();
    put(8'h47, 1'b1);
    send_zeros(20);
    @(negedge clk);
    din_valid = 0;
    #2 reset = 0;
    #1;
    total++;
    if ({dout, dout_valid, dout_sop, group_sop, sync_err} !== 12'h000) begin
      bad++;
      $display("[TB] FAIL async_reset: got d=%h v=%b sop=%b gsop=%b err=%b want all 0",
               dout, dout_valid, dout_sop, group_sop, sync_err);
    end
    model_reset();
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1;
    put(8'h00, 1'b0);
    put(8'h47, 1'b1);
    total++;
    if (last_dout !== 8'hB8) begin
      bad++; $display("[TB] FAIL post_reset_sync: got %h want b8", last_dout);
    end
    put(8'h00, 1'b0);
    total++;
    if (last_dout !== 8'h03) begin
      bad++; $display("[TB] FAIL post_reset_byte1: got %h want 03", last_dout);
    end
  endtask

  // The whole run is bounded in time. Any stall is reported as a failure.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_sync_start();
    test_group_wrap();
    test_gaps();
    test_mid_sop();
    test_missing_sop();
    test_bad_sync();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
